// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit adder with carry-in. The operands are cut into CHUNK-bit slices
//   and each pipeline stage adds one slice, passing its carry to the next
//   stage. Latency is STAGES = WIDTH/CHUNK cycles and one result can be
//   accepted every cycle. The whole pipe advances or holds as a unit, so a
//   stalled consumer freezes every stage, bubbles included.
//
//   Optional feature macro: OVERFLOW_EN. When it is defined, the Ovf port
//   (signed overflow, registered alongside Sum) is present.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   A/B/Cin are valid this cycle
//   in_ready   the block accepts A/B/Cin this cycle
//   A, B       WIDTH-bit operands
//   Cin        carry into bit 0
//   out_valid  Sum/Cout (and Ovf) are valid
//   out_ready  the consumer takes the result this cycle
//   Sum        (A + B + Cin) mod 2^WIDTH
//   Cout       carry out of bit WIDTH-1
//   Ovf        signed overflow (OVERFLOW_EN builds only)
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef OVERFLOW_EN
    ,
    output logic             Ovf
`endif
);

    localparam int STAGES = WIDTH / CHUNK;

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be >= 1 and a multiple of CHUNK");
    end

    // One slice of the ripple: CHUNK-bit add with carry, carry-out on top.
    function automatic logic [CHUNK:0] add_slice(input logic [CHUNK-1:0] a,
                                                 input logic [CHUNK-1:0] b,
                                                 input logic             c);
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c};
    endfunction

    // Per-stage state: valid, carry, partial sum (slices 0..k filled in) and
    // the operand skew registers carrying the slices not yet added.
    logic             vld_p [STAGES];
    logic             cry_p [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];

    logic advance;

    assign out_valid = vld_p[STAGES-1];
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;
    assign Sum       = sum_p[STAGES-1];
    assign Cout      = cry_p[STAGES-1];

`ifdef OVERFLOW_EN
    logic ovf_p;
    assign Ovf = ovf_p;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] src_a;
        logic [WIDTH-1:0] src_b;
        logic [WIDTH-1:0] src_sum;
        logic             src_c;
        logic             src_v;
        logic [CHUNK:0]   slice;
        logic [WIDTH-1:0] nxt_sum;

        if (k == 0) begin : g_first
            assign src_a   = A;
            assign src_b   = B;
            assign src_c   = Cin;
            assign src_v   = in_valid;
            assign src_sum = '0;
        end else begin : g_next
            assign src_a   = a_p[k-1];
            assign src_b   = b_p[k-1];
            assign src_c   = cry_p[k-1];
            assign src_v   = vld_p[k-1];
            assign src_sum = sum_p[k-1];
        end

        assign slice = add_slice(src_a[k*CHUNK +: CHUNK], src_b[k*CHUNK +: CHUNK], src_c);

        always_comb begin
            nxt_sum = src_sum;
            nxt_sum[k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
        end

        // ---- stage k register boundary ----
        always_ff @(posedge clk) begin
            if (advance) begin
                a_p[k] <= src_a;
                b_p[k] <= src_b;
            end
        end

        if (k == STAGES - 1) begin : g_last
            // Output stage: its data is visible on the ports, so it clears on reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p[k] <= 1'b0;
                    sum_p[k] <= '0;
                    cry_p[k] <= 1'b0;
                end else if (advance) begin
                    vld_p[k] <= src_v;
                    sum_p[k] <= nxt_sum;
                    cry_p[k] <= slice[CHUNK];
                end
            end
`ifdef OVERFLOW_EN
            // The top slice is added here, so both operand sign bits and the
            // result sign bit are all available in this stage.
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_p <= 1'b0;
                end else if (advance) begin
                    ovf_p <= (src_a[WIDTH-1] == src_b[WIDTH-1]) &
                             (nxt_sum[WIDTH-1] != src_a[WIDTH-1]);
                end
            end
`endif
        end else begin : g_mid
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_p[k] <= 1'b0;
                end else if (advance) begin
                    vld_p[k] <= src_v;
                end
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    sum_p[k] <= nxt_sum;
                    cry_p[k] <= slice[CHUNK];
                end
            end
        end
    end

endmodule
